// File: rtl/image_writer_if.sv
// image_writer_if: pixel stream ingress plus synchronous memory write port.
interface image_writer_if #(
    parameter int BIT_DEPTH  = 8,
    parameter int ADDR_WIDTH = 17
);
    logic                  in_valid;
    logic                  in_ready;
    logic [BIT_DEPTH-1:0]  in_data;
    logic                  in_last;
    logic                  write_enable;
    logic [ADDR_WIDTH-1:0] write_addr;
    logic [BIT_DEPTH-1:0]  write_data;
    modport master (output in_valid, in_data, in_last, input in_ready, write_enable, write_addr, write_data);
    modport slave  (input in_valid, in_data, in_last, output in_ready, write_enable, write_addr, write_data);
endinterface

// File: rtl/image_writer.sv
// image_writer: captures one streamed frame into image memory at addresses 0..MEM_SIZE-1.
// Optional IMAGE_WRITER_CHECKSUM_EN adds a 16-bit running sum of accepted pixels.
module image_writer #(
    parameter int BIT_DEPTH  = 8,
    parameter int ADDR_WIDTH = 17,
    parameter int MEM_SIZE   = 76800
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    image_writer_if.slave       bus,
    output logic                busy,
    output logic                done,
`ifdef IMAGE_WRITER_CHECKSUM_EN
    output logic                error,
    output logic [15:0]         checksum
`else
    output logic                error
`endif
);
    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    if (MEM_SIZE < 1 || longint'(MEM_SIZE) > (longint'(1) << ADDR_WIDTH))
        $error("image_writer: MEM_SIZE must be in 1..2**ADDR_WIDTH");

    state_t                state;
    logic [ADDR_WIDTH-1:0] count;
    logic                  accept;
    logic                  last_beat;

    assign bus.in_ready = state == WRITE;
    assign busy         = state != IDLE;
    assign accept       = bus.in_valid && bus.in_ready;
    assign last_beat    = count == ADDR_WIDTH'(MEM_SIZE - 1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            count            <= '0;
            bus.write_enable <= 1'b0;
            bus.write_addr   <= '0;
            bus.write_data   <= '0;
            done             <= 1'b0;
            error            <= 1'b0;
`ifdef IMAGE_WRITER_CHECKSUM_EN
            checksum         <= '0;
`endif
        end else begin
            bus.write_enable <= accept;
            done             <= 1'b0;
            if (accept) begin
                bus.write_addr <= count;
                bus.write_data <= bus.in_data;
                count          <= count + 1'b1;
`ifdef IMAGE_WRITER_CHECKSUM_EN
                checksum       <= checksum + 16'(bus.in_data);
`endif
            end
            case (state)
                IDLE: if (start) begin
                    state    <= WRITE;
                    count    <= '0;
                    error    <= 1'b0;
`ifdef IMAGE_WRITER_CHECKSUM_EN
                    checksum <= '0;
`endif
                end
                // A frame ends on the terminal count or an early in_last; any disagreement between the two is an error.
                WRITE: if (accept && (last_beat || bus.in_last)) begin
                    state <= DONE;
                    done  <= 1'b1;
                    error <= error | (last_beat ^ bus.in_last);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/image_writer.md
Name: image_writer

Overview:
Stream-to-memory counterpart of the image read path. Accepts a pixel stream (camera/Ethernet ingress) over a valid/ready handshake and writes one full frame into image memory through a synchronous write port, with addresses running 0..MEM_SIZE-1. Reports frame completion with a one-cycle `done` pulse and flags frames whose `in_last` marker does not match the pixel count.

Parameters:
- BIT_DEPTH, 8, pixel width in bits.
- ADDR_WIDTH, 17, image memory address width.
- MEM_SIZE, 76800, pixels per frame (320x240); must satisfy 1 <= MEM_SIZE <= 2**ADDR_WIDTH (elaboration-time check).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  begin frame capture; honoured only in IDLE
- in_valid  in  1  stream pixel valid
- in_ready  out  1  stream ready; combinational, equals (state==WRITE)
- in_data  in  BIT_DEPTH  stream pixel
- in_last  in  1  producer's end-of-frame marker
- write_enable  out  1  memory write strobe (registered)
- write_addr  out  ADDR_WIDTH  memory write address (registered)
- write_data  out  BIT_DEPTH  memory write data (registered)
- busy  out  1  high in WRITE and DONE
- done  out  1  one-cycle frame-complete pulse (registered)
- error  out  1  sticky frame-length mismatch; cleared by start or reset

Behaviour:
- Reset values: state=IDLE, pixel counter=0. Outputs write_enable=0, write_addr=0, write_data=0, done=0, error=0, busy=0, in_ready=0.
- States are IDLE, WRITE and DONE.
- IDLE:
  - in_ready=0.
  - start=1: clear pixel counter, clear error, go to WRITE.
- WRITE:
  - in_ready=1. A beat is accepted when in_valid && in_ready.
  - On an accepted beat in cycle N: in cycle N+1, write_enable=1, write_addr=counter value at N, write_data=in_data at N. The counter increments.
  - write_enable=0 in any cycle with no accepted beat in the prior cycle. write_addr and write_data hold their last values.
  - The last beat is the accepted beat with counter==MEM_SIZE-1. On it: go to DONE. If in_last=0 on that beat, set error (long/unterminated frame).
  - in_last=1 on an accepted beat with counter<MEM_SIZE-1: that pixel is still written, error is set, go to DONE (short frame).
  - start is ignored in WRITE.
- DONE:
  - Lasts exactly one cycle. done=1 and busy=1; the final write_enable is issued in the same cycle. Return to IDLE.
  - in_ready=0, so no beat is accepted while DONE is active.
- Latency: accepted beat to memory write is 1 cycle. Accepted last beat to done is 1 cycle, coincident with the last write.
- Counter arithmetic: ADDR_WIDTH wide, no wrap within a frame, because the terminal count ends the frame. With MEM_SIZE==2**ADDR_WIDTH the counter may wrap to 0 after the last beat; this is harmless, as the counter is cleared on start.
- A start asserted in the DONE cycle is ignored (state is not IDLE). The earliest new frame is start in the first IDLE cycle.
- in_data and in_last are don't-care when in_valid=0. in_valid may drop mid-frame with no effect other than a gap in writes.
- Reset mid-frame: return to IDLE immediately and drop the pending registered write. Pixels already written stay in memory. No done pulse.
- error holds through IDLE until the next start.

Optional Feature:
- Macro: IMAGE_WRITER_CHECKSUM_EN.
- Enabled:
  - Adds output `checksum [15:0]`.
  - The register is cleared on start and reset.
  - On each accepted beat it is updated as checksum <= checksum + zero-extended in_data, modulo 2^16.
  - The value is final, and stable, in the done cycle. It holds until the next start.
- Disabled: the port and register are absent; all other behaviour is identical.

Test Plan:
- Normal frame: MEM_SIZE=16, start, then 16 back-to-back beats with data 0x10..0x1F and in_last on beat 15.
  - Writes addr 0..15 with data 0x10..0x1F, each 1 cycle after acceptance.
  - done pulses once, coincident with the addr 15 write; error=0.
  - With the checksum macro: checksum=0x0178.
- Backpressure/gaps: same frame with in_valid toggling 1,0,1,0.
  - Exactly 16 writes, addresses contiguous, no write in the cycle after an in_valid=0 cycle; done after the 16th.
- Short frame: in_last on beat 9 (addr 9).
  - 10 writes (addr 0..9), done pulses, error=1, in_ready=0 afterwards.
  - error stays 1 until the next start, which clears it.
- Missing in_last: 16 beats, in_last never set.
  - 16 writes, done, error=1.
- Start handling and reset: start pulsed during WRITE is ignored (no counter clear). Reset asserted after 5 accepted beats:
  - Next cycle: write_enable=0, in_ready=0, busy=0, no done.
  - Subsequent start captures a full frame from addr 0.
- Idle guard: in_valid=1 in IDLE without start -> in_ready=0, no writes, counter unchanged.
